// File: rtl/asignar_en_vacia_pkg.sv
// Shared types and constants for the board writer: FSM states, default board
// geometry and the 6-bit LFSR feedback mask (x^6 + x^5 + 1).
package asignar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WRITE,
    FULLR
  } estado_t;

  localparam int FILAS_DEF = 8;
  localparam int COLS_DEF  = 8;
  localparam int ANCHO_DEF = 8;
  localparam int N_CELDAS  = FILAS_DEF * COLS_DEF;
  localparam int IDX_W     = $clog2(N_CELDAS);

  localparam logic [5:0] LFSR_TAPS = 6'b110000;

endpackage

// File: rtl/asignar_en_vacia_lfsr6.sv
// 6-bit Fibonacci LFSR, shifts left every cycle; feedback is the XOR of the tapped bits.
module lfsr6
  import asignar_pkg::*;
#(
  parameter logic [5:0] SEED = 6'h2D
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [5:0] q
);

  logic [5:0] q_q;
  logic [5:0] q_d;

  assign q_d = {q_q[4:0], ^(q_q & LFSR_TAPS)};
  assign q   = q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= SEED;
    else        q_q <= q_d;
  end

endmodule

// File: rtl/asignar_en_vacia.sv
// Board owner: on a request, scans one cell per cycle from a start index and
// writes the value into the first empty cell, or reports a full board.
module asignar_en_vacia
  import asignar_pkg::*;
#(
  parameter int         FILAS     = FILAS_DEF,
  parameter int         COLS      = COLS_DEF,
  parameter int         ANCHO     = ANCHO_DEF,
  parameter int         ALEATORIO = 1,
  parameter logic [5:0] SEMILLA   = 6'h2D
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ANCHO-1:0]             valor,
  input  logic                         clear,
  output logic                         busy,
  output logic                         done,
  output logic                         full,
  output logic [$clog2(FILAS)-1:0]     fila_out,
  output logic [$clog2(COLS)-1:0]      col_out,
  output logic [FILAS*COLS*ANCHO-1:0]  matriz_out,
  input  logic [$clog2(FILAS)-1:0]     rd_fila,
  input  logic [$clog2(COLS)-1:0]      rd_col,
  output logic [ANCHO-1:0]             rd_dato
);

  localparam int N  = FILAS * COLS;
  localparam int FW = $clog2(FILAS);
  localparam int CW = $clog2(COLS);
  localparam int IW = FW + CW;

  estado_t                    state_q;
  logic [IW-1:0]              cnt_q, base_q, idx_q;
  logic [ANCHO-1:0]           valor_q;
  logic [N-1:0][ANCHO-1:0]    board_q;
  logic                       done_q, full_q;
  logic [FW-1:0]              fila_q;
  logic [CW-1:0]              col_q;
  logic [5:0]                 lfsr_q;
  logic [IW-1:0]              scan_idx;

  lfsr6 #(.SEED(SEMILLA)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  // Wraps naturally modulo N because N is a power of two.
  assign scan_idx = base_q + cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      valor_q <= '0;
      board_q <= '0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
      fila_q  <= '0;
      col_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (clear) begin
            board_q <= '0;
          end else if (start && valor != '0) begin
            valor_q <= valor;
            base_q  <= (ALEATORIO != 0) ? IW'(lfsr_q) : '0;
            cnt_q   <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (board_q[scan_idx] == '0) begin
            idx_q   <= scan_idx;
            state_q <= WRITE;
          end else if (cnt_q == IW'(N - 1)) begin
            state_q <= FULLR;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WRITE: begin
          board_q[idx_q]   <= valor_q;
          {fila_q, col_q}  <= idx_q;
          done_q           <= 1'b1;
          full_q           <= 1'b0;
          state_q          <= IDLE;
        end
        FULLR: begin
          done_q  <= 1'b1;
          full_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = (state_q == SCAN) || (state_q == WRITE);
  assign done       = done_q;
  assign full       = full_q;
  assign fila_out   = fila_q;
  assign col_out    = col_q;
  assign matriz_out = board_q;
  assign rd_dato    = board_q[{rd_fila, rd_col}];

endmodule

// File: tb/tb_asignar_en_vacia.sv
// Directed bench: deterministic instance (ALEATORIO=0) for placement, full,
// clear and interference cases; LFSR instance (ALEATORIO=1) for start index.
module tb_asignar_en_vacia;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_a = 1'b0, start_b = 1'b0, clear = 1'b0;
  logic [7:0]   valor = '0;
  logic [2:0]   rd_fila = '0, rd_col = '0;
  logic         busy_a, done_a, full_a, busy_b, done_b, full_b;
  logic [2:0]   fila_a, col_a, fila_b, col_b;
  logic [511:0] matriz_a, matriz_b;
  logic [7:0]   rd_dato_a, rd_dato_b;

  logic [63:0][7:0] exp_m;
  logic [5:0]       lfsr_m;
  logic [5:0]       exp_base;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  // Reference LFSR: x^6+x^5+1, shifting left, advancing every clock out of reset.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_m <= 6'h2D;
    else        lfsr_m <= {lfsr_m[4:0], lfsr_m[5] ^ lfsr_m[4]};

  asignar_en_vacia #(.ALEATORIO(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .valor(valor), .clear(clear),
    .busy(busy_a), .done(done_a), .full(full_a), .fila_out(fila_a), .col_out(col_a),
    .matriz_out(matriz_a), .rd_fila(rd_fila), .rd_col(rd_col), .rd_dato(rd_dato_a));

  asignar_en_vacia #(.ALEATORIO(1), .SEMILLA(6'h2D)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .valor(valor), .clear(clear),
    .busy(busy_b), .done(done_b), .full(full_b), .fila_out(fila_b), .col_out(col_b),
    .matriz_out(matriz_b), .rd_fila(rd_fila), .rd_col(rd_col), .rd_dato(rd_dato_b));

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request on dut_a; lat = number of edges after the sampling edge
  // until done is seen (-1 if it never shows up).
  task automatic ins(input logic [7:0] v, output int lat);
    @(negedge clk);
    start_a = 1'b1; valor = v;
    @(posedge clk); #1;
    start_a = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done_a) begin lat = n; break; end
    end
  endtask

  initial begin
    int lat, bad, ndone, seen;
    exp_m = '0;

    // Reset state
    #3;
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_full", full_a, 1'b0);
    chk("rst_fila", fila_a, 3'd0);
    chk("rst_col", col_a, 3'd0);
    chk("rst_matriz_a", matriz_a, '0);
    chk("rst_matriz_b", matriz_b, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Empty board: lands at (0,0), done two edges after start
    rd_fila = 3'd0; rd_col = 3'd0;
    ins(8'd27, lat);
    exp_m[0] = 8'd27;
    chk("t1_lat", lat, 2);
    chk("t1_full", full_a, 1'b0);
    chk("t1_fila", fila_a, 3'd0);
    chk("t1_col", col_a, 3'd0);
    chk("t1_rd", rd_dato_a, 8'd27);

    // Cells 1..9 filled in order with values 2..10
    bad = 0;
    for (int i = 1; i < 10; i++) begin
      ins(8'(i + 1), lat);
      exp_m[i] = 8'(i + 1);
      if (lat != i + 2) bad++;
    end
    chk("fill1_lat", bad, 0);

    // First empty cell is idx 10 -> (1,2), latency 12
    rd_fila = 3'd1; rd_col = 3'd2;
    ins(8'd42, lat);
    exp_m[10] = 8'd42;
    chk("t2_lat", lat, 12);
    chk("t2_fila", fila_a, 3'd1);
    chk("t2_col", col_a, 3'd2);
    chk("t2_rd", rd_dato_a, 8'd42);
    chk("t2_matriz", matriz_a, exp_m);

    // Fill the rest; last write is idx 63 -> (7,7)
    bad = 0;
    for (int i = 11; i < 64; i++) begin
      ins(8'(i + 1), lat);
      exp_m[i] = 8'(i + 1);
      if (lat != i + 2) bad++;
    end
    chk("fill2_lat", bad, 0);

    // Full board: 64 probes then FULLR, coordinates hold
    ins(8'd15, lat);
    chk("full_lat", lat, 65);
    chk("full_flag", full_a, 1'b1);
    chk("full_fila", fila_a, 3'd7);
    chk("full_col", col_a, 3'd7);
    chk("full_matriz", matriz_a, exp_m);

    // Clear then insert lands at (0,0)
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    exp_m = '0;
    chk("clr_matriz", matriz_a, exp_m);
    rd_fila = 3'd0; rd_col = 3'd0;
    ins(8'd10, lat);
    exp_m[0] = 8'd10;
    chk("clr_ins_lat", lat, 2);
    chk("clr_ins_full", full_a, 1'b0);
    chk("clr_ins_pos", {fila_a, col_a}, 6'd0);
    chk("clr_ins_rd", rd_dato_a, 8'd10);

    // clear + start together: clear wins, start dropped
    @(negedge clk); clear = 1'b1; start_a = 1'b1; valor = 8'd5;
    @(posedge clk); #1; clear = 1'b0; start_a = 1'b0;
    exp_m = '0;
    chk("cs_matriz", matriz_a, exp_m);
    seen = 0;
    repeat (5) begin @(posedge clk); #1; if (busy_a || done_a) seen++; end
    chk("cs_no_req", seen, 0);

    // start/clear during SCAN are ignored; exactly one done
    for (int i = 0; i < 5; i++) begin ins(8'(i + 1), lat); exp_m[i] = 8'(i + 1); end
    @(negedge clk); start_a = 1'b1; valor = 8'd50;
    @(posedge clk); #1; start_a = 1'b0;
    ndone = 0; lat = -1; seen = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done_a) begin ndone++; if (lat < 0) lat = n; end
      if (n == 2) begin seen = int'(busy_a); start_a = 1'b1; valor = 8'd99; clear = 1'b1; end
      if (n == 3) begin start_a = 1'b0; clear = 1'b0; end
    end
    exp_m[5] = 8'd50;
    chk("sc_busy", seen, 1);
    chk("sc_ndone", ndone, 1);
    chk("sc_lat", lat, 7);
    chk("sc_pos", {fila_a, col_a}, 6'd5);
    chk("sc_matriz", matriz_a, exp_m);

    // start with valor 0 is ignored
    @(negedge clk); start_a = 1'b1; valor = 8'd0;
    @(posedge clk); #1; start_a = 1'b0;
    seen = 0;
    repeat (5) begin @(posedge clk); #1; if (busy_a || done_a) seen++; end
    chk("v0_ignored", seen, 0);

    // Reset mid-SCAN aborts and wipes the board
    @(negedge clk); start_a = 1'b1; valor = 8'd60;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_busy_pre", busy_a, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", busy_a, 1'b0);
    chk("mid_done", done_a, 1'b0);
    chk("mid_matriz", matriz_a, '0);
    @(negedge clk); rst_n = 1'b1;

    // LFSR start index on empty board: lands at the current LFSR value
    repeat (5) @(posedge clk);
    @(negedge clk);
    exp_base = lfsr_m;
    rd_fila = exp_base[5:3]; rd_col = exp_base[2:0];
    start_b = 1'b1; valor = 8'd77;
    @(posedge clk); #1; start_b = 1'b0;
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (done_b) begin lat = n; break; end
    end
    chk("rnd_lat", lat, 2);
    chk("rnd_fila", fila_b, exp_base[5:3]);
    chk("rnd_col", col_b, exp_base[2:0]);
    chk("rnd_rd", rd_dato_b, 8'd77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
